instr_fetch_unit: RTL

//  Instruction fetch stage in front of control_decode. On a request it reads two bytes from

---
 rtl/instr_fetch_unit_pkg.sv | 26 ++
 rtl/instr_fetch_unit_wait_timer.sv | 43 ++++
 rtl/instr_fetch_unit.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_pkg
//   Shared definitions for the instruction fetch unit: FSM state encodings,
//   default address width, instruction width and the byte-assembly helper.
//   No ports.
// -----------------------------------------------------------------------------
package instr_fetch_unit_pkg;

  localparam int IFU_ADDR_W_DEF = 16;
  localparam int IFU_INSTR_W    = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LO    = 3'd1,
    ST_HI    = 3'd2,
    ST_DONE  = 3'd3,
    ST_FAULT = 3'd4
  } ifu_state_e;

  // Little-endian: the first byte fetched is the low byte.
  function automatic logic [IFU_INSTR_W-1:0] ifu_assemble(input logic [7:0] hi_byte,
                                                          input logic [7:0] lo_byte);
    return {hi_byte, lo_byte};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_wait_timer.sv
// -----------------------------------------------------------------------------
// ifu_wait_timer
//   Counts consecutive memory wait cycles of one beat and flags the cycle in
//   which the TIMEOUT_CYCLES-th wait occurs. TIMEOUT_CYCLES = 0 disables it.
// Ports
//   i_clk      system clock
//   i_rst_n    asynchronous active-low reset
//   i_clear    restart the count (beat done, new state, no request)
//   i_enable   this cycle is a wait cycle (mem_req && !mem_ready)
//   o_expired  this wait cycle is the last one allowed
// -----------------------------------------------------------------------------
module ifu_wait_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST_CNT =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic TMR_ON = (TIMEOUT_CYCLES != 0);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (TMR_ON && i_enable && (r_cnt != LAST_CNT)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Fires on the wait cycle that would be count TIMEOUT_CYCLES, so the FSM
  // leaves for FAULT right after exactly TIMEOUT_CYCLES wait cycles.
  assign o_expired = TMR_ON && i_enable && (r_cnt == LAST_CNT);

endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//   Fetches a 16-bit little-endian instruction as two byte beats from a
//   byte-wide ready-handshake memory, holds it with a valid flag, flushes on
//   branches and enters a sticky FAULT state if a beat waits too long.
//   Optional feature macro: IFU_PREFETCH_EN (speculative fetch of base+2 into
//   a one-entry prefetch buffer while the current instruction is held).
//
//   state | meaning
//   IDLE  | no instruction held or in flight
//   LO    | low-byte beat at base (or prefetch address when speculative)
//   HI    | high-byte beat at base+1
//   DONE  | instruction held valid
//   FAULT | memory timeout, terminal until reset
//
// Ports
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_fetch_req/_addr     fetch request and PC (sampled when !o_stall)
//   i_flush               abort in-flight fetch
//   o_instr/_valid        assembled instruction and valid flag
//   o_stall               fetch in progress, requests ignored
//   o_mem_req/_addr       memory read request and byte address
//   i_mem_rdata/_ready    memory read data and beat-complete strobe
//   o_fetch_fault         sticky timeout fault
// -----------------------------------------------------------------------------
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int ADDR_W         = IFU_ADDR_W_DEF,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_fetch_req,
  input  logic [ADDR_W-1:0]      i_fetch_addr,
  input  logic                   i_flush,
  output logic [IFU_INSTR_W-1:0] o_instr,
  output logic                   o_instr_valid,
  output logic                   o_stall,
  output logic                   o_mem_req,
  output logic [ADDR_W-1:0]      o_mem_addr,
  input  logic [7:0]             i_mem_rdata,
  input  logic                   i_mem_ready,
  output logic                   o_fetch_fault
);

  ifu_state_e             r_state, w_state_nxt;
  logic [ADDR_W-1:0]      r_base, w_base_nxt;
  logic [7:0]             r_lo, w_lo_nxt;
  logic [IFU_INSTR_W-1:0] r_instr, w_instr_nxt;
  logic                   r_instr_valid, w_valid_nxt;
  logic                   w_restart;
  logic                   w_expired;
  logic                   w_tmr_clr;
  logic                   w_tmr_en;
  logic [ADDR_W-1:0]      w_cur_addr;
  logic                   w_beat_state;

  assign w_beat_state = (r_state == ST_LO) || (r_state == ST_HI);

`ifdef IFU_PREFETCH_EN
  logic                   r_spec, w_spec_nxt;
  logic                   r_pend, w_pend_nxt;
  logic [ADDR_W-1:0]      r_pend_addr, w_pend_addr_nxt;
  logic                   r_pf_valid, w_pf_valid_nxt;
  logic [ADDR_W-1:0]      r_pf_addr, w_pf_addr_nxt;
  logic [IFU_INSTR_W-1:0] r_pf_data, w_pf_data_nxt;
  logic                   w_dem_req;
  logic [ADDR_W-1:0]      w_dem_addr;

  // A demand that arrived during a speculative beat is serviced from DONE.
  assign w_dem_req  = r_pend || i_fetch_req;
  assign w_dem_addr = r_pend ? r_pend_addr : i_fetch_addr;
  assign w_cur_addr = r_spec ? r_pf_addr : r_base;
  assign o_stall    = (r_state == ST_FAULT) ||
                      (w_beat_state && (!r_spec || r_pend)) ||
                      ((r_state == ST_DONE) && r_pend);
`else
  assign w_cur_addr = r_base;
  assign o_stall    = w_beat_state || (r_state == ST_FAULT);
`endif

  assign o_mem_req     = w_beat_state;
  assign o_mem_addr    = (r_state == ST_HI) ? (w_cur_addr + ADDR_W'(1)) : w_cur_addr;
  assign o_instr       = r_instr;
  assign o_instr_valid = r_instr_valid;
  assign o_fetch_fault = (r_state == ST_FAULT);

  assign w_tmr_en  = o_mem_req && !i_mem_ready;
  assign w_tmr_clr = w_restart || (w_state_nxt != r_state) || !o_mem_req || i_mem_ready;

  ifu_wait_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clear   (w_tmr_clr),
    .i_enable  (w_tmr_en),
    .o_expired (w_expired)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_base_nxt  = r_base;
    w_lo_nxt    = r_lo;
    w_instr_nxt = r_instr;
    w_valid_nxt = r_instr_valid;
    w_restart   = 1'b0;
`ifdef IFU_PREFETCH_EN
    w_spec_nxt      = r_spec;
    w_pend_nxt      = r_pend;
    w_pend_addr_nxt = r_pend_addr;
    w_pf_valid_nxt  = r_pf_valid;
    w_pf_addr_nxt   = r_pf_addr;
    w_pf_data_nxt   = r_pf_data;
    case (r_state)
      ST_IDLE: begin
        if (i_flush) begin
          w_valid_nxt = 1'b0;
        end
        if (i_fetch_req) begin
          w_base_nxt  = i_fetch_addr;
          w_valid_nxt = 1'b0;
          w_state_nxt = ST_LO;
          w_restart   = 1'b1;
        end
      end
      ST_DONE: begin
        if (i_flush) begin
          w_valid_nxt    = 1'b0;
          w_pf_valid_nxt = 1'b0;
          w_pend_nxt     = 1'b0;
          w_state_nxt    = ST_IDLE;
          if (i_fetch_req) begin
            w_base_nxt  = i_fetch_addr;
            w_state_nxt = ST_LO;
            w_restart   = 1'b1;
          end
        end else if (w_dem_req) begin
          w_pend_nxt     = 1'b0;
          w_pf_valid_nxt = 1'b0;
          w_base_nxt     = w_dem_addr;
          if (r_pf_valid && (w_dem_addr == r_pf_addr)) begin
            w_instr_nxt = r_pf_data;
            w_valid_nxt = 1'b1;
          end else begin
            w_valid_nxt = 1'b0;
            w_state_nxt = ST_LO;
            w_restart   = 1'b1;
          end
        end else if (!r_pf_valid) begin
          w_spec_nxt    = 1'b1;
          w_pf_addr_nxt = r_base + ADDR_W'(2);
          w_state_nxt   = ST_LO;
          w_restart     = 1'b1;
        end
      end
      ST_LO, ST_HI: begin
        if (i_flush) begin
          w_valid_nxt    = 1'b0;
          w_pf_valid_nxt = 1'b0;
          w_spec_nxt     = 1'b0;
          w_pend_nxt     = 1'b0;
          w_state_nxt    = ST_IDLE;
          w_restart      = 1'b1;
          if (i_fetch_req) begin
            w_base_nxt  = i_fetch_addr;
            w_state_nxt = ST_LO;
          end
        end else begin
          if (r_spec && !r_pend && i_fetch_req) begin
            w_pend_nxt      = 1'b1;
            w_pend_addr_nxt = i_fetch_addr;
          end
          if (i_mem_ready) begin
            if (r_state == ST_LO) begin
              if (r_spec && r_pend && (r_pend_addr != r_pf_addr)) begin
                // Pending demand misses the prefetch: abandon it after this beat.
                w_spec_nxt     = 1'b0;
                w_pend_nxt     = 1'b0;
                w_pf_valid_nxt = 1'b0;
                w_base_nxt     = r_pend_addr;
                w_valid_nxt    = 1'b0;
                w_restart      = 1'b1;
              end else begin
                w_lo_nxt    = i_mem_rdata;
                w_state_nxt = ST_HI;
              end
            end else if (r_spec) begin
              w_pf_data_nxt  = ifu_assemble(i_mem_rdata, r_lo);
              w_pf_valid_nxt = 1'b1;
              w_spec_nxt     = 1'b0;
              w_state_nxt    = ST_DONE;
            end else begin
              w_instr_nxt = ifu_assemble(i_mem_rdata, r_lo);
              w_valid_nxt = 1'b1;
              w_state_nxt = ST_DONE;
            end
          end else if (w_expired) begin
            w_valid_nxt    = 1'b0;
            w_spec_nxt     = 1'b0;
            w_pend_nxt     = 1'b0;
            w_pf_valid_nxt = 1'b0;
            w_state_nxt    = ST_FAULT;
          end
        end
      end
      ST_FAULT: ;
      default: w_state_nxt = ST_IDLE;
    endcase
`else
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (i_flush) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = ST_IDLE;
        end
        if (i_fetch_req) begin
          w_base_nxt  = i_fetch_addr;
          w_valid_nxt = 1'b0;
          w_state_nxt = ST_LO;
          w_restart   = 1'b1;
        end
      end
      ST_LO, ST_HI: begin
        // Flush wins over mem_ready in the same cycle; the beat is dropped.
        if (i_flush) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = ST_IDLE;
          w_restart   = 1'b1;
          if (i_fetch_req) begin
            w_base_nxt  = i_fetch_addr;
            w_state_nxt = ST_LO;
          end
        end else if (i_mem_ready) begin
          if (r_state == ST_LO) begin
            w_lo_nxt    = i_mem_rdata;
            w_state_nxt = ST_HI;
          end else begin
            w_instr_nxt = ifu_assemble(i_mem_rdata, r_lo);
            w_valid_nxt = 1'b1;
            w_state_nxt = ST_DONE;
          end
        end else if (w_expired) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = ST_FAULT;
        end
      end
      ST_FAULT: ;
      default: w_state_nxt = ST_IDLE;
    endcase
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_base        <= '0;
      r_lo          <= '0;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_base        <= w_base_nxt;
      r_lo          <= w_lo_nxt;
      r_instr       <= w_instr_nxt;
      r_instr_valid <= w_valid_nxt;
    end
  end

`ifdef IFU_PREFETCH_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_spec      <= 1'b0;
      r_pend      <= 1'b0;
      r_pend_addr <= '0;
      r_pf_valid  <= 1'b0;
      r_pf_addr   <= '0;
      r_pf_data   <= '0;
    end else begin
      r_spec      <= w_spec_nxt;
      r_pend      <= w_pend_nxt;
      r_pend_addr <= w_pend_addr_nxt;
      r_pf_valid  <= w_pf_valid_nxt;
      r_pf_addr   <= w_pf_addr_nxt;
      r_pf_data   <= w_pf_data_nxt;
    end
  end
`endif

endmodule
